branch_cmp_pipe: RTL and testbench
==================================

# branch_cmp_pipe

Parametrised, pipelined magnitude comparator for the RISC-V branch unit. It generalises the fixed 32-bit combinational comparator in three ways: operand width is a parameter, signed or unsigned compare is selected per operation, and the LSB-first chunk cascade is split across registered stages. Each stage has valid/ready flow control, a flush, and a carried tag. It sits between operand read and the PC-select logic and returns the branch decision and the comparison flags.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- CHUNK, 8, bits resolved per pipeline stage (1..WIDTH)
- TAG_W, 4, width of the user tag carried alongside each operation
- Derived: STAGES = ceil(WIDTH/CHUNK)
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous; kills every operation in flight
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_a, in_b  in  WIDTH  operands (rs1, rs2)
- in_op  in  3  RISC-V funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready
- out_eq  out  1  a == b
- out_lt  out  1  a < b, signed or unsigned per op
- out_taken  out  1  branch condition true
- out_err  out  1  in_op was 010 or 011
- out_tag  out  TAG_W  tag of this result

## Operation
- Chunk k covers bits [k*CHUNK +: CHUNK]; stage k resolves chunk k, LSB chunk first.
- Bits above WIDTH-1 in the top chunk are zero-padded.
- Signed ops (BLT, BGE; op[1]=0) invert bit WIDTH-1 of both operands before the top chunk compares. eq is unaffected.
- Per-chunk cascade, with gt/lt initialised to 0 at stage 0:
  - gt' = cg | (ce & gt)
  - lt' = cl | (ce & lt)
  - eq = ~gt & ~lt after the last chunk.
- Branch decision:
  - BEQ: taken = eq
  - BNE: taken = ~eq
  - BLT/BLTU: taken = lt
  - BGE/BGEU: taken = ~lt
  - 010/011: taken = 0, err = 1; eq and lt are still computed.
- Each stage register holds: valid, remaining operand bits, partial gt/lt, op, tag.
- The last stage register drives the outputs directly. No combinational path from inputs to outputs.
- Flow control:
  - ready_k = ~valid_k | ready_(k+1)
  - ready_STAGES = out_ready
  - in_ready = ready_0 & ~flush
- Flush clears every stage valid in the same edge. An input offered during the flush cycle is not accepted.
- Results leave in acceptance order; tags are never reordered or dropped.

## Timing
- Reset (async assert): all stage valids = 0, out_valid = 0, out_eq/out_lt/out_taken/out_err = 0, out_tag = 0.
- Deassertion of rst_n is synchronised externally; the block needs no extra cycles after it.
- Latency: accept at edge N → out_valid high after edge N+STAGES-1. For STAGES=1 that is the accepting edge itself.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure: with out_ready = 0 the pipe fills to STAGES entries, then in_ready = 0 in the same cycle as the stall reaches stage 0. Bubbles collapse.
- out_valid with out_ready = 0: all out_* hold stable until the handshake.
- Flush concurrent with an output handshake: the output is considered consumed; the next cycle has out_valid = 0.
- Reset mid-operation: every in-flight operation is lost; no partial result appears after reset.
- WIDTH not a multiple of CHUNK (e.g. 10/4): 3 stages; the top chunk holds 2 real bits.

## Structure
- Package branch_cmp_pkg:
  - funct3 localparams: OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  - function is_signed(op), function decide(op, eq, lt) → {taken, err}
- Sub-module cmp_chunk: combinational CHUNK-bit compare producing ce, cg, cl. One instance per stage via generate.
- branch_cmp_pipe holds the stage registers, handshake chain and flush.

## Test plan
- Reset: assert rst_n=0 mid-run with 3 ops in flight → immediately out_valid=0, in_ready=1. After release, no stale result ever appears.
- WIDTH=32, CHUNK=8, a=0x8000_0000, b=0x0000_0001:
  - BLT → out_valid on the 4th edge, lt=1, taken=1.
  - BLTU → lt=0, taken=0.
  - BGE → taken=0.
- a=b=0xDEAD_BEEF: BEQ → eq=1, taken=1; BNE → taken=0; BGEU → taken=1.
- Backpressure: 6 back-to-back ops with tags 0..5, out_ready low after the first result → in_ready drops once 4 are held. Release → tags 1..5 emerge in order, one per cycle, values match the model.
- Flush with 3 ops in flight plus in_valid high on the flush cycle → none of the 4 ever produces out_valid. The next op accepted afterwards returns correctly after 4 cycles.
- op=010, a=5, b=3 → err=1, taken=0, eq=0, lt=0.
- WIDTH=10, CHUNK=4: 2000 random ops with random valid/ready → all results match the reference model.

Source files
------------

// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the pipelined branch comparator: funct3 encodings
// and the helpers that turn comparison flags into a branch decision.
package branch_cmp_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t OP_BEQ  = 3'b000;
  localparam funct3_t OP_BNE  = 3'b001;
  localparam funct3_t OP_BLT  = 3'b100;
  localparam funct3_t OP_BGE  = 3'b101;
  localparam funct3_t OP_BLTU = 3'b110;
  localparam funct3_t OP_BGEU = 3'b111;

  // Every funct3 with bit 1 clear compares signed; eq is unaffected either way.
  function automatic logic is_signed(input funct3_t op);
    logic s;
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: s = 1'b1;
      default:                        s = 1'b0;
    endcase
    return s;
  endfunction

  // Returns {taken, err}.
  function automatic logic [1:0] decide(input funct3_t op, input logic eq, input logic lt);
    logic [1:0] r;
    case (op)
      OP_BEQ:           r = {eq, 1'b0};
      OP_BNE:           r = {~eq, 1'b0};
      OP_BLT, OP_BLTU:  r = {lt, 1'b0};
      OP_BGE, OP_BGEU:  r = {~lt, 1'b0};
      default:          r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cmp_pipe_chunk.sv
// Combinational compare of one CHUNK-bit slice of the two operands.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_ce,
  output logic             o_cg,
  output logic             o_cl
);

  assign o_ce = (i_a == i_b);
  assign o_cg = (i_a > i_b);
  assign o_cl = (i_a < i_b);

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator: one operand chunk per stage, LSB chunk first,
// with valid/ready flow control, flush and a tag carried alongside each op.
module branch_cmp_pipe
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_taken,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = STAGES * CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam logic [PW-1:0] SIGN_MASK = PW'(1) << (WIDTH - 1);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_gt;
  logic [STAGES-1:0] r_lt;
  logic [PW-1:0]     r_a   [STAGES];
  logic [PW-1:0]     r_b   [STAGES];
  logic [2:0]        r_op  [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];

  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_srcValid;
  logic [STAGES-1:0] w_srcGt;
  logic [STAGES-1:0] w_srcLt;
  logic [PW-1:0]     w_srcA   [STAGES];
  logic [PW-1:0]     w_srcB   [STAGES];
  logic [2:0]        w_srcOp  [STAGES];
  logic [TAG_W-1:0]  w_srcTag [STAGES];
  logic [STAGES-1:0] w_ce;
  logic [STAGES-1:0] w_cg;
  logic [STAGES-1:0] w_cl;
  logic              w_eq;
  logic [1:0]        w_dec;
  logic              w_unused;

  always_comb begin
    w_ready = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = ~r_valid[k] | w_ready[k+1];
    end
  end

  assign in_ready = w_ready[0] & ~flush;

  // Stage k's input is the incoming op for k=0, otherwise stage k-1's register.
  // The sign bit is flipped at entry so signed order becomes unsigned order.
  always_comb begin
    w_srcValid = '0;
    w_srcGt    = '0;
    w_srcLt    = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_srcA[k]   = '0;
      w_srcB[k]   = '0;
      w_srcOp[k]  = '0;
      w_srcTag[k] = '0;
    end
    w_srcValid[0] = in_valid & in_ready;
    w_srcA[0]     = PW'(in_a) ^ (is_signed(in_op) ? SIGN_MASK : '0);
    w_srcB[0]     = PW'(in_b) ^ (is_signed(in_op) ? SIGN_MASK : '0);
    w_srcOp[0]    = in_op;
    w_srcTag[0]   = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      w_srcValid[k] = r_valid[k-1];
      w_srcGt[k]    = r_gt[k-1];
      w_srcLt[k]    = r_lt[k-1];
      w_srcA[k]     = r_a[k-1];
      w_srcB[k]     = r_b[k-1];
      w_srcOp[k]    = r_op[k-1];
      w_srcTag[k]   = r_tag[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
      .i_a  (w_srcA[k][CHUNK-1:0]),
      .i_b  (w_srcB[k][CHUNK-1:0]),
      .o_ce (w_ce[k]),
      .o_cg (w_cg[k]),
      .o_cl (w_cl[k])
    );
  end

  // Operands are shifted down as they advance so the next chunk is always at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_gt    <= '0;
      r_lt    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_op[k]  <= '0;
        r_tag[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_srcValid[k];
          r_gt[k]    <= w_cg[k] | (w_ce[k] & w_srcGt[k]);
          r_lt[k]    <= w_cl[k] | (w_ce[k] & w_srcLt[k]);
          r_a[k]     <= w_srcA[k] >> CHUNK;
          r_b[k]     <= w_srcB[k] >> CHUNK;
          r_op[k]    <= w_srcOp[k];
          r_tag[k]   <= w_srcTag[k];
        end
      end
    end
  end

  assign w_eq  = ~r_gt[LAST] & ~r_lt[LAST];
  assign w_dec = decide(r_op[LAST], w_eq, r_lt[LAST]);

  assign out_valid = r_valid[LAST];
  assign out_eq    = r_valid[LAST] & w_eq;
  assign out_lt    = r_valid[LAST] & r_lt[LAST];
  assign out_taken = r_valid[LAST] & w_dec[1];
  assign out_err   = r_valid[LAST] & w_dec[0];
  assign out_tag   = r_tag[LAST];

  // The last stage's shifted operands are always empty.
  assign w_unused = ^{r_a[LAST], r_b[LAST]};

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Self-checking bench: directed checks on a 32/8 instance, randomized
// valid/ready/flush traffic on a 10/4 instance, both against a scoreboard.
module tb_branch_cmp_pipe;
  import branch_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        f32, iv32, ir32, ov32, or32, eq32, lt32, tk32, er32;
  logic [31:0] a32, b32;
  logic [2:0]  op32;
  logic [3:0]  tag32, otag32;

  logic        f10, iv10, ir10, ov10, or10, eq10, lt10, tk10, er10;
  logic [9:0]  a10, b10;
  logic [2:0]  op10;
  logic [3:0]  tag10, otag10;

  logic [7:0] q32[$];
  logic [7:0] q10[$];
  int acc10 = 0;

  branch_cmp_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(f32), .in_valid(iv32), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .in_op(op32), .in_tag(tag32),
    .out_valid(ov32), .out_ready(or32), .out_eq(eq32), .out_lt(lt32),
    .out_taken(tk32), .out_err(er32), .out_tag(otag32));

  branch_cmp_pipe #(.WIDTH(10), .CHUNK(4), .TAG_W(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .flush(f10), .in_valid(iv10), .in_ready(ir10),
    .in_a(a10), .in_b(b10), .in_op(op10), .in_tag(tag10),
    .out_valid(ov10), .out_ready(or10), .out_eq(eq10), .out_lt(lt10),
    .out_taken(tk10), .out_err(er10), .out_tag(otag10));

  // Reference result {eq, lt, taken, err} from integer arithmetic on w-bit operands.
  function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input int w);
    longint sa, sb;
    logic sgn, eq, lt, tk, er;
    sgn = (op == OP_BLT) || (op == OP_BGE) || (op == OP_BEQ) || (op == OP_BNE);
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    eq = (a == b);
    lt = (sa < sb);
    er = (op == 3'b010) || (op == 3'b011);
    case (op)
      OP_BEQ:          tk = eq;
      OP_BNE:          tk = !eq;
      OP_BLT, OP_BLTU: tk = lt;
      OP_BGE, OP_BGEU: tk = !lt;
      default:         tk = 1'b0;
    endcase
    return {eq, lt, tk, er};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [3:0] tag);
    iv32 = 1'b1; a32 = a; b32 = b; op32 = op; tag32 = tag;
  endtask

  task automatic tick32();
    logic fl;
    logic [7:0] e;
    #1;
    fl = f32;
    if (iv32 && ir32) q32.push_back({model(a32, b32, op32, 32), tag32});
    if (ov32 && or32) begin
      if (q32.size() == 0) checkOutput("spurious32", 64'(1), 64'(0));
      else begin
        e = q32.pop_front();
        checkOutput("res32", 64'({eq32, lt32, tk32, er32, otag32}), 64'(e));
      end
    end
    @(posedge clk); #1;
    if (fl) q32.delete();
  endtask

  task automatic tick10();
    logic fl;
    logic [7:0] e;
    #1;
    fl = f10;
    if (iv10 && ir10) begin
      q10.push_back({model({22'b0, a10}, {22'b0, b10}, op10, 10), tag10});
      acc10++;
    end
    if (ov10 && or10) begin
      if (q10.size() == 0) checkOutput("spurious10", 64'(1), 64'(0));
      else begin
        e = q10.pop_front();
        checkOutput("res10", 64'({eq10, lt10, tk10, er10, otag10}), 64'(e));
      end
    end
    @(posedge clk); #1;
    if (fl) q10.delete();
  endtask

  task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] tag, input logic [3:0] exp);
    int lat;
    applyStimulus(a, b, op, tag);
    #1;
    checkOutput({name, "_inrdy"}, 64'(ir32), 64'(1));
    tick32();
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 10) begin
      tick32();
      lat++;
    end
    checkOutput({name, "_lat"}, 64'(lat), 64'(3));
    checkOutput({name, "_flags"}, 64'({eq32, lt32, tk32, er32}), 64'(exp));
    checkOutput({name, "_tag"}, 64'(otag32), 64'(tag));
    tick32();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] bpA [6];
    logic [31:0] bpB [6];
    logic [2:0]  bpOp [6];
    logic [2:0]  opTab [8];
    logic [9:0]  corner [4];
    int cycles;

    opTab  = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, 3'b010, 3'b011};
    corner = '{10'h000, 10'h3FF, 10'h200, 10'h1FF};
    f32 = 0; iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0; tag32 = 0;
    f10 = 0; iv10 = 0; or10 = 1; a10 = 0; b10 = 0; op10 = 0; tag10 = 0;

    #12;
    checkOutput("rst_ov32", 64'(ov32), 64'(0));
    checkOutput("rst_out32", 64'({eq32, lt32, tk32, er32, otag32}), 64'(0));
    checkOutput("rst_ov10", 64'(ov10), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run32("blt",  32'h8000_0000, 32'h0000_0001, OP_BLT,  4'd1, 4'b0110);
    run32("bltu", 32'h8000_0000, 32'h0000_0001, OP_BLTU, 4'd2, 4'b0000);
    run32("bge",  32'h8000_0000, 32'h0000_0001, OP_BGE,  4'd3, 4'b0100);
    run32("beq",  32'hDEAD_BEEF, 32'hDEAD_BEEF, OP_BEQ,  4'd4, 4'b1010);
    run32("bne",  32'hDEAD_BEEF, 32'hDEAD_BEEF, OP_BNE,  4'd5, 4'b1000);
    run32("bgeu", 32'hDEAD_BEEF, 32'hDEAD_BEEF, OP_BGEU, 4'd6, 4'b1010);
    run32("err",  32'd5,         32'd3,         3'b010,  4'd7, 4'b0001);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, $urandom, OP_BLTU, 4'(i));
      tick32();
    end
    iv32 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_ov", 64'(ov32), 64'(0));
    checkOutput("rstmid_inrdy", 64'(ir32), 64'(1));
    q32.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick32();
      checkOutput("rst_stale", 64'(ov32), 64'(0));
    end

    // Backpressure: six ops, output stalled after the first is consumed.
    for (int i = 0; i < 6; i++) begin
      bpA[i] = $urandom; bpB[i] = $urandom; bpOp[i] = opTab[$urandom_range(0, 5)];
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bpA[i], bpB[i], bpOp[i], 4'(i));
      tick32();
    end
    or32 = 1'b0;
    applyStimulus(bpA[5], bpB[5], bpOp[5], 4'd5);
    #1;
    checkOutput("bp_inrdy", 64'(ir32), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick32();
      checkOutput("bp_hold_v", 64'(ov32), 64'(1));
      checkOutput("bp_hold_tag", 64'(otag32), 64'(1));
    end
    or32 = 1'b1;
    tick32();
    iv32 = 1'b0;
    for (int t = 2; t <= 5; t++) begin
      checkOutput("bp_v", 64'(ov32), 64'(1));
      checkOutput("bp_tag", 64'(otag32), 64'(t));
      tick32();
    end
    checkOutput("bp_empty", 64'(q32.size()), 64'(0));

    // Flush with three in flight and a fourth offered on the flush cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, $urandom, OP_BGE, 4'(8 + i));
      tick32();
    end
    applyStimulus($urandom, $urandom, OP_BLT, 4'd11);
    f32 = 1'b1;
    #1;
    checkOutput("flush_inrdy", 64'(ir32), 64'(0));
    tick32();
    f32 = 1'b0;
    iv32 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("flush_ov", 64'(ov32), 64'(0));
      tick32();
    end
    run32("postflush", 32'd7, 32'd9, OP_BLTU, 4'd12, 4'b0110);

    // Randomized traffic on the 10-bit / 4-bit-chunk instance.
    cycles = 0;
    while (acc10 < 2000 && cycles < 20000) begin
      iv10  = ($urandom_range(0, 3) != 0);
      a10   = 10'($urandom);
      b10   = ($urandom_range(0, 3) == 0) ? a10 : 10'($urandom);
      if ($urandom_range(0, 7) == 0) a10 = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) b10 = corner[$urandom_range(0, 3)];
      op10  = opTab[$urandom_range(0, 7)];
      tag10 = 4'($urandom);
      or10  = ($urandom_range(0, 3) != 0);
      f10   = ($urandom_range(0, 99) == 0);
      tick10();
      cycles++;
    end
    checkOutput("rand_accepted", 64'(acc10 >= 2000), 64'(1));
    iv10 = 1'b0; or10 = 1'b1; f10 = 1'b0;
    for (int i = 0; i < 20 && q10.size() > 0; i++) tick10();
    checkOutput("rand_drain", 64'(q10.size()), 64'(0));
    tick10();
    checkOutput("rand_idle", 64'(ov10), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
